pipe_hazard_ctrl: RTL and testbench
===================================

# pipe_hazard_ctrl

Pipeline hazard and sequencing controller for the 5-stage MIPS core. Sits beside the IF/ID register and drives its write-enable and flush, the PC write-enable and the ID/EX bubble. It resolves load-use, branch/jump and instruction-fetch-wait hazards, and runs a multi-cycle multiply/divide unit (MDU) busy window. It also keeps a stall-cycle counter.

## Interface
Parameters:
- MDU_LAT, 32, cycles the MDU is busy after mdu_start; legal range 1..255.

Ports:
- clk  in  1  core clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-high reset
- id_opcode  in  6  opcode field of the instruction held in IF/ID
- id_funct  in  6  funct field (bits 5:0) of the instruction held in IF/ID
- id_rs, id_rt  in  5 each  source register fields of the instruction held in IF/ID
- ex_mem_read  in  1  the instruction in ID/EX is a load
- ex_rt  in  5  destination register of the instruction in ID/EX
- ex_branch_taken  in  1  branch resolved taken in EX this cycle
- imem_ready  in  1  instruction memory returns valid data this cycle
- pc_write  out  1  PC register load enable
- ifid_write  out  1  IF/ID load enable
- ifid_flush  out  1  IF/ID loads a NOP (0x00000000)
- idex_flush  out  1  ID/EX loads a bubble
- mdu_start  out  1  one-cycle start pulse to the MDU
- mdu_busy  out  1  high while the controller is in the MDU_BUSY state
- stall_cycles  out  32  saturating count of non-reset cycles with pc_write=0

## Operation
Decode classes:
- MDU op: id_opcode=0x00 and id_funct ∈ {0x18,0x19,0x1A,0x1B}.
- HI/LO read: id_opcode=0x00 and id_funct ∈ {0x10,0x12}.
- Jump: id_opcode ∈ {0x02,0x03}.
- Load-use: ex_mem_read=1, ex_rt≠0, and (ex_rt=id_rs or ex_rt=id_rt).

States:
- RUN
- MDU_BUSY, with an 8-bit down-counter cnt.

Per-cycle priority. Outputs are combinational from the state and the inputs. The first matching row applies.
1. ex_branch_taken: pc_write=1, ifid_write=1, ifid_flush=1, idex_flush=1, mdu_start=0. An MDU op in ID is squashed.
2. Load-use: pc_write=0, ifid_write=0, idex_flush=1.
3. MDU hazard: the state is MDU_BUSY and ID holds an MDU op or a HI/LO read. Outputs are the same as row 2.
4. imem_ready=0: pc_write=0, ifid_write=1, ifid_flush=1, idex_flush=0. The instruction in ID advances; IF/ID receives a bubble.
5. Jump in ID: pc_write=1, ifid_write=1, ifid_flush=1.
6. Otherwise: pc_write=1, ifid_write=1, both flushes 0.

mdu_start rules:
- mdu_start=1 iff ID holds an MDU op, the state is RUN, and row 1, 2 or 3 does not apply.
- Rows 4–6 allow mdu_start.
- RUN→MDU_BUSY on mdu_start; cnt is loaded with MDU_LAT.
- In MDU_BUSY, cnt decrements every cycle. At cnt=1 the next state is RUN.
- A taken branch does not abort MDU_BUSY: the operation already started is architecturally committed.

stall_cycles:
- Increments when rst=0 and pc_write=0.
- Saturates at 0xFFFFFFFF.

## Timing
- Reset (async assert, any state): state=RUN, cnt=0, stall_cycles=0. While rst=1 the outputs are forced to pc_write=0, ifid_write=0, ifid_flush=1, idex_flush=1, mdu_start=0, mdu_busy=0.
- Outputs take effect at the first rising edge after rst deasserts.
- Hazard outputs have zero latency: they are valid in the same cycle as the inputs that cause them.
- A load-use hazard stalls exactly 1 cycle. The next cycle, the load sits in EX/MEM and ex_mem_read reflects the bubble.
- With mdu_start at edge T, mdu_busy=1 for cycles T+1..T+MDU_LAT and 0 at T+MDU_LAT+1. A stalled HI/LO read proceeds in cycle T+MDU_LAT+1.
- With MDU_LAT=1, MDU_BUSY lasts exactly one cycle.
- Rows 1 and 2 together (branch taken while a load-use pattern is present): the flush wins; no stall is counted.

## Structure
- Shared package pipe_pkg holds:
  - the opcode and funct constants: OP_RTYPE, OP_J, OP_JAL, FN_MULT, FN_MULTU, FN_DIV, FN_DIVU, FN_MFHI, FN_MFLO;
  - the state encoding: ST_RUN, ST_MDU_BUSY.
- One sub-module, hazard_detect: purely combinational load-use and MDU-hazard comparators.
- The FSM, the counter and the output priority logic live in the top module.

## Test plan
- Load-use: ex_mem_read=1, ex_rt=8, id_rs=8 → one cycle of pc_write=0, ifid_write=0, idex_flush=1; stall_cycles increments by 1.
- ex_rt=0 with id_rs=0 and ex_mem_read=1 → no stall.
- Taken branch coincident with load-use (ex_branch_taken=1, ex_rt=id_rt=5) → ifid_flush=1, idex_flush=1, pc_write=1; stall_cycles unchanged.
- MULT (funct 0x18) in ID with MDU_LAT=4 → mdu_start pulses once; mdu_busy=1 for 4 cycles. An MFLO arriving next is held 4 cycles, then issues with pc_write=1.
- imem_ready=0 for 3 cycles → pc_write=0 and ifid_flush=1 each cycle; ID/EX is not bubbled; stall_cycles increments by 3.
- rst asserted mid-MDU_BUSY (cnt=2) → mdu_busy=0 immediately, state RUN, stall_cycles=0. A jump (opcode 0x02) after release → ifid_flush=1 for one cycle.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared constants, state encoding and decode helpers for the pipeline
// hazard controller.
package pipe_pkg;

  // Primary opcodes
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;

  // R-type funct codes touching the multiply/divide unit
  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1A;
  localparam logic [5:0] FN_DIVU  = 6'h1B;

  // Controller state encoding
  typedef enum logic {
    ST_RUN      = 1'b0,
    ST_MDU_BUSY = 1'b1
  } state_t;

  // One cycle's worth of pipeline control
  typedef struct packed {
    logic pc_write;
    logic ifid_write;
    logic ifid_flush;
    logic idex_flush;
    logic mdu_start;
  } ctrl_t;

  // Instruction starts a multiply or divide
  function automatic logic is_mdu_op(input logic [5:0] opcode, input logic [5:0] funct);
    return (opcode == OP_RTYPE) &&
           ((funct == FN_MULT) || (funct == FN_MULTU) ||
            (funct == FN_DIV)  || (funct == FN_DIVU));
  endfunction

  // Instruction reads the HI/LO result registers
  function automatic logic is_hilo_read(input logic [5:0] opcode, input logic [5:0] funct);
    return (opcode == OP_RTYPE) && ((funct == FN_MFHI) || (funct == FN_MFLO));
  endfunction

  // Unconditional jump resolved in ID
  function automatic logic is_jump(input logic [5:0] opcode);
    return (opcode == OP_J) || (opcode == OP_JAL);
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// Combinational hazard comparators: load-use against the instruction in
// ID/EX, and MDU-result hazards while the multiply/divide unit is busy.
module hazard_detect
  import pipe_pkg::*;
(
  input  logic [5:0] id_opcode,
  input  logic [5:0] id_funct,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       ex_mem_read,
  input  logic [4:0] ex_rt,
  input  logic       mdu_active,
  output logic       load_use,
  output logic       mdu_op,
  output logic       mdu_hazard
);

  logic hilo_read;

  // $zero is never a real dependency, so a load targeting r0 never stalls
  always_comb begin
    load_use   = ex_mem_read && (ex_rt != 5'd0) &&
                 ((ex_rt == id_rs) || (ex_rt == id_rt));
    mdu_op     = is_mdu_op(id_opcode, id_funct);
    hilo_read  = is_hilo_read(id_opcode, id_funct);
    mdu_hazard = mdu_active && (mdu_op || hilo_read);
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard and sequencing controller: drives PC/IF-ID enables and
// flushes, runs the MDU busy window and counts stalled cycles.
//
//   state        | meaning
//   -------------+-----------------------------------------------
//   ST_RUN       | normal issue; an MDU op in ID may start the MDU
//   ST_MDU_BUSY  | MDU computing; cnt counts remaining busy cycles
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int MDU_LAT = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  id_opcode,
  input  logic [5:0]  id_funct,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        ex_mem_read,
  input  logic [4:0]  ex_rt,
  input  logic        ex_branch_taken,
  input  logic        imem_ready,
  output logic        pc_write,
  output logic        ifid_write,
  output logic        ifid_flush,
  output logic        idex_flush,
  output logic        mdu_start,
  output logic        mdu_busy,
  output logic [31:0] stall_cycles
);

  localparam logic [7:0] LAT8 = 8'(MDU_LAT);

  state_t     state;
  state_t     state_nxt;
  logic [7:0] cnt;
  logic [7:0] cnt_nxt;
  ctrl_t      ctrl;

  logic load_use;
  logic mdu_op;
  logic mdu_hazard;

  hazard_detect u_hazard_detect (
    .id_opcode   (id_opcode),
    .id_funct    (id_funct),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .ex_mem_read (ex_mem_read),
    .ex_rt       (ex_rt),
    .mdu_active  (state == ST_MDU_BUSY),
    .load_use    (load_use),
    .mdu_op      (mdu_op),
    .mdu_hazard  (mdu_hazard)
  );

  // State register and busy-window down-counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_RUN;
      cnt   <= 8'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next state: a started MDU op is committed, so branches never abort the window
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    unique case (state)
      ST_RUN: begin
        if (ctrl.mdu_start) begin
          state_nxt = ST_MDU_BUSY;
          cnt_nxt   = LAT8;
        end
      end
      ST_MDU_BUSY: begin
        cnt_nxt = cnt - 8'd1;
        if (cnt <= 8'd1) begin
          state_nxt = ST_RUN;
        end
      end
      default: begin
        state_nxt = ST_RUN;
        cnt_nxt   = 8'd0;
      end
    endcase
  end

  // Output priority: branch flush > load-use > MDU hazard > fetch wait > jump > issue
  always_comb begin
    ctrl = '{pc_write: 1'b1, ifid_write: 1'b1, ifid_flush: 1'b0,
             idex_flush: 1'b0, mdu_start: 1'b0};
    if (rst) begin
      ctrl = '{pc_write: 1'b0, ifid_write: 1'b0, ifid_flush: 1'b1,
               idex_flush: 1'b1, mdu_start: 1'b0};
    end else if (ex_branch_taken) begin
      ctrl.ifid_flush = 1'b1;
      ctrl.idex_flush = 1'b1;
    end else if (load_use || mdu_hazard) begin
      ctrl.pc_write   = 1'b0;
      ctrl.ifid_write = 1'b0;
      ctrl.idex_flush = 1'b1;
    end else begin
      ctrl.mdu_start = mdu_op && (state == ST_RUN);
      if (!imem_ready) begin
        ctrl.pc_write   = 1'b0;
        ctrl.ifid_flush = 1'b1;
      end else if (is_jump(id_opcode)) begin
        ctrl.ifid_flush = 1'b1;
      end
    end
  end

  // Saturating count of cycles in which the PC did not advance
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles <= 32'd0;
    end else if (!ctrl.pc_write && (stall_cycles != 32'hFFFF_FFFF)) begin
      stall_cycles <= stall_cycles + 32'd1;
    end
  end

  assign pc_write   = ctrl.pc_write;
  assign ifid_write = ctrl.ifid_write;
  assign ifid_flush = ctrl.ifid_flush;
  assign idex_flush = ctrl.idex_flush;
  assign mdu_start  = ctrl.mdu_start;
  assign mdu_busy   = !rst && (state == ST_MDU_BUSY);

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl (MDU_LAT = 4).
module tb_pipe_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  id_opcode;
  logic [5:0]  id_funct;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic        ex_mem_read;
  logic [4:0]  ex_rt;
  logic        ex_branch_taken;
  logic        imem_ready;
  logic        pc_write;
  logic        ifid_write;
  logic        ifid_flush;
  logic        idex_flush;
  logic        mdu_start;
  logic        mdu_busy;
  logic [31:0] stall_cycles;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] exp_stall = 32'd0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.MDU_LAT(4)) dut (
    .clk             (clk),
    .rst             (rst),
    .id_opcode       (id_opcode),
    .id_funct        (id_funct),
    .id_rs           (id_rs),
    .id_rt           (id_rt),
    .ex_mem_read     (ex_mem_read),
    .ex_rt           (ex_rt),
    .ex_branch_taken (ex_branch_taken),
    .imem_ready      (imem_ready),
    .pc_write        (pc_write),
    .ifid_write      (ifid_write),
    .ifid_flush      (ifid_flush),
    .idex_flush      (idex_flush),
    .mdu_start       (mdu_start),
    .mdu_busy        (mdu_busy),
    .stall_cycles    (stall_cycles)
  );

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // addi r2, r3, ... with no EX hazard, fetch ready
  task automatic set_idle();
    id_opcode = 6'h08; id_funct = 6'h00; id_rs = 5'd3; id_rt = 5'd2;
    ex_mem_read = 1'b0; ex_rt = 5'd0; ex_branch_taken = 1'b0; imem_ready = 1'b1;
  endtask

  // Packed {pc_write, ifid_write, ifid_flush, idex_flush, mdu_start, mdu_busy}
  function automatic logic [5:0] outs();
    return {pc_write, ifid_write, ifid_flush, idex_flush, mdu_start, mdu_busy};
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    set_idle();
    #3;
    n_cmp++; if (outs() !== 6'b001100) begin n_bad++; $display("FAIL reset_outs got=%b exp=%b", outs(), 6'b001100); end
    n_cmp++; if (stall_cycles !== 32'd0) begin n_bad++; $display("FAIL reset_stall got=%0d exp=0", stall_cycles); end
    tick(); tick();
    rst = 1'b0;
    #2;
    n_cmp++; if (outs() !== 6'b110000) begin n_bad++; $display("FAIL release_outs got=%b exp=%b", outs(), 6'b110000); end
    tick();
    n_cmp++; if (stall_cycles !== exp_stall) begin n_bad++; $display("FAIL release_stall got=%0d exp=%0d", stall_cycles, exp_stall); end
  endtask

  task automatic test_load_use();
    ex_mem_read = 1'b1; ex_rt = 5'd8; id_rs = 5'd8;
    #2;
    n_cmp++; if (outs() !== 6'b000100) begin n_bad++; $display("FAIL load_use_outs got=%b exp=%b", outs(), 6'b000100); end
    tick();
    exp_stall = exp_stall + 32'd1;
    set_idle();
    #2;
    n_cmp++; if (outs() !== 6'b110000) begin n_bad++; $display("FAIL load_use_resume got=%b exp=%b", outs(), 6'b110000); end
    n_cmp++; if (stall_cycles !== exp_stall) begin n_bad++; $display("FAIL load_use_stall got=%0d exp=%0d", stall_cycles, exp_stall); end
    // same hazard through the rt field
    ex_mem_read = 1'b1; ex_rt = 5'd2; id_rs = 5'd9; id_rt = 5'd2;
    #1;
    n_cmp++; if (outs() !== 6'b000100) begin n_bad++; $display("FAIL load_use_rt got=%b exp=%b", outs(), 6'b000100); end
    tick();
    exp_stall = exp_stall + 32'd1;
    set_idle();
  endtask

  task automatic test_zero_reg();
    ex_mem_read = 1'b1; ex_rt = 5'd0; id_rs = 5'd0; id_rt = 5'd0;
    #2;
    n_cmp++; if (outs() !== 6'b110000) begin n_bad++; $display("FAIL zero_reg_outs got=%b exp=%b", outs(), 6'b110000); end
    tick();
    set_idle();
    #1;
    n_cmp++; if (stall_cycles !== exp_stall) begin n_bad++; $display("FAIL zero_reg_stall got=%0d exp=%0d", stall_cycles, exp_stall); end
  endtask

  task automatic test_branch_over_load_use();
    ex_branch_taken = 1'b1; ex_mem_read = 1'b1; ex_rt = 5'd5; id_rt = 5'd5;
    #2;
    n_cmp++; if (outs() !== 6'b111100) begin n_bad++; $display("FAIL branch_loaduse_outs got=%b exp=%b", outs(), 6'b111100); end
    tick();
    set_idle();
    #1;
    n_cmp++; if (stall_cycles !== exp_stall) begin n_bad++; $display("FAIL branch_loaduse_stall got=%0d exp=%0d", stall_cycles, exp_stall); end
    // taken branch squashes an MDU op in ID: no start, no busy window
    ex_branch_taken = 1'b1; id_opcode = 6'h00; id_funct = 6'h1A;
    #1;
    n_cmp++; if (outs() !== 6'b111100) begin n_bad++; $display("FAIL branch_squash_mdu got=%b exp=%b", outs(), 6'b111100); end
    tick();
    set_idle();
    #1;
    n_cmp++; if (mdu_busy !== 1'b0) begin n_bad++; $display("FAIL branch_squash_busy got=%b exp=0", mdu_busy); end
  endtask

  task automatic test_mdu_window();
    id_opcode = 6'h00; id_funct = 6'h18;
    #2;
    n_cmp++; if (outs() !== 6'b110010) begin n_bad++; $display("FAIL mult_start got=%b exp=%b", outs(), 6'b110010); end
    tick();
    id_funct = 6'h12;
    for (int i = 1; i <= 4; i++) begin
      #2;
      n_cmp++; if (outs() !== 6'b000101) begin n_bad++; $display("FAIL mflo_hold_%0d got=%b exp=%b", i, outs(), 6'b000101); end
      tick();
      exp_stall = exp_stall + 32'd1;
    end
    #2;
    n_cmp++; if (outs() !== 6'b110000) begin n_bad++; $display("FAIL mflo_issue got=%b exp=%b", outs(), 6'b110000); end
    n_cmp++; if (stall_cycles !== exp_stall) begin n_bad++; $display("FAIL mdu_stall got=%0d exp=%0d", stall_cycles, exp_stall); end
    tick();
    set_idle();
  endtask

  task automatic test_imem_wait();
    imem_ready = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      #2;
      n_cmp++; if (outs() !== 6'b011000) begin n_bad++; $display("FAIL imem_wait_%0d got=%b exp=%b", i, outs(), 6'b011000); end
      tick();
      exp_stall = exp_stall + 32'd1;
    end
    imem_ready = 1'b1;
    #2;
    n_cmp++; if (outs() !== 6'b110000) begin n_bad++; $display("FAIL imem_resume got=%b exp=%b", outs(), 6'b110000); end
    n_cmp++; if (stall_cycles !== exp_stall) begin n_bad++; $display("FAIL imem_stall got=%0d exp=%0d", stall_cycles, exp_stall); end
  endtask

  task automatic test_reset_mid_busy();
    id_opcode = 6'h00; id_funct = 6'h19;
    tick();            // MULTU started; cnt=4
    set_idle();
    tick();            // cnt=3
    tick();            // cnt=2
    n_cmp++; if (mdu_busy !== 1'b1) begin n_bad++; $display("FAIL busy_before_rst got=%b exp=1", mdu_busy); end
    #1;
    rst = 1'b1;
    #1;
    n_cmp++; if (outs() !== 6'b001100) begin n_bad++; $display("FAIL mid_rst_outs got=%b exp=%b", outs(), 6'b001100); end
    n_cmp++; if (stall_cycles !== 32'd0) begin n_bad++; $display("FAIL mid_rst_stall got=%0d exp=0", stall_cycles); end
    tick();
    rst = 1'b0;
    exp_stall = 32'd0;
    id_opcode = 6'h00; id_funct = 6'h10;
    #2;
    n_cmp++; if (outs() !== 6'b110000) begin n_bad++; $display("FAIL post_rst_mfhi got=%b exp=%b", outs(), 6'b110000); end
    tick();
    id_opcode = 6'h02; id_funct = 6'h00;
    #2;
    n_cmp++; if (outs() !== 6'b111000) begin n_bad++; $display("FAIL jump_flush got=%b exp=%b", outs(), 6'b111000); end
    tick();
    set_idle();
    #2;
    n_cmp++; if (outs() !== 6'b110000) begin n_bad++; $display("FAIL after_jump got=%b exp=%b", outs(), 6'b110000); end
    n_cmp++; if (stall_cycles !== exp_stall) begin n_bad++; $display("FAIL post_rst_stall got=%0d exp=%0d", stall_cycles, exp_stall); end
  endtask

  task automatic test_back_to_back();
    // MDU op arriving while busy waits, then starts once the window closes
    id_opcode = 6'h00; id_funct = 6'h18;
    tick();
    id_funct = 6'h1B;
    for (int i = 1; i <= 4; i++) begin
      #2;
      n_cmp++; if (outs() !== 6'b000101) begin n_bad++; $display("FAIL b2b_hold_%0d got=%b exp=%b", i, outs(), 6'b000101); end
      tick();
      exp_stall = exp_stall + 32'd1;
    end
    #2;
    n_cmp++; if (outs() !== 6'b110010) begin n_bad++; $display("FAIL b2b_restart got=%b exp=%b", outs(), 6'b110010); end
    tick();
    set_idle();
    #2;
    n_cmp++; if (mdu_busy !== 1'b1) begin n_bad++; $display("FAIL b2b_busy got=%b exp=1", mdu_busy); end
    n_cmp++; if (stall_cycles !== exp_stall) begin n_bad++; $display("FAIL b2b_stall got=%0d exp=%0d", stall_cycles, exp_stall); end
    for (int i = 0; i < 4; i++) tick();
    n_cmp++; if (mdu_busy !== 1'b0) begin n_bad++; $display("FAIL b2b_done got=%b exp=0", mdu_busy); end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_zero_reg();
    test_branch_over_load_use();
    test_mdu_window();
    test_imem_wait();
    test_reset_mid_busy();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
